// File: rtl/exu_disp.sv
// ---------------------------------------------------------------------------
// exu_disp : dispatch scheduler between decoder and execution units.
//
// Steers each decoded instruction to exactly one of ALU / BJP / MULDIV / AGU
// over a valid/ready handshake. Long-latency ops (MULDIV or AGU with a
// register write) are tracked in an outstanding-instruction table (OITF) so
// that younger instructions with RAW/WAW dependencies on them are held back.
// Illegal instructions are held until the OITF has drained, then raise a
// single-cycle exception request.
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   i_valid / i_ready               decoder handshake
//   i_grp_*                         one-hot target unit group
//   i_illegal                       decoder illegal flag
//   i_rs1en/i_rs2en/i_rdwen, *idx   operand / destination enables and indices
//   i_flush                         kills the current dispatch attempt
//   o_*_valid / i_*_ready           per-unit request handshake
//   o_itag                          OITF tag of a dispatched long op
//   o_illegal_valid                 exception request
//   i_lwb_valid / i_lwb_itag        long-latency writeback retiring oldest entry
//   o_oitf_empty/full/cnt           OITF status
//   o_ret_err                       sticky: retire with bad tag or while empty
// ---------------------------------------------------------------------------
module exu_disp #(
    parameter int RFIDX_W    = 5,
    parameter int OITF_DEPTH = 4,
    parameter int ITAG_W     = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_valid,
    output logic               i_ready,
    input  logic               i_grp_alu,
    input  logic               i_grp_bjp,
    input  logic               i_grp_muldiv,
    input  logic               i_grp_agu,
    input  logic               i_illegal,
    input  logic               i_rs1en,
    input  logic               i_rs2en,
    input  logic               i_rdwen,
    input  logic [RFIDX_W-1:0] i_rs1idx,
    input  logic [RFIDX_W-1:0] i_rs2idx,
    input  logic [RFIDX_W-1:0] i_rdidx,
    input  logic               i_flush,
    output logic               o_alu_valid,
    output logic               o_bjp_valid,
    output logic               o_muldiv_valid,
    output logic               o_agu_valid,
    input  logic               i_alu_ready,
    input  logic               i_bjp_ready,
    input  logic               i_muldiv_ready,
    input  logic               i_agu_ready,
    output logic [ITAG_W-1:0]  o_itag,
    output logic               o_illegal_valid,
    input  logic               i_lwb_valid,
    input  logic [ITAG_W-1:0]  i_lwb_itag,
    output logic               o_oitf_empty,
    output logic               o_oitf_full,
    output logic [ITAG_W:0]    o_oitf_cnt,
    output logic               o_ret_err
);

    localparam logic [ITAG_W:0] PTR_ONE = (ITAG_W+1)'(1);

    // Pointers carry an extra MSB wrap bit to tell full from empty.
    logic [ITAG_W:0]    wr_ptr_r;
    logic [ITAG_W:0]    rd_ptr_r;
    logic [ITAG_W:0]    cnt_r;
    logic               ret_err_r;
    logic [OITF_DEPTH-1:0] vld_r;
    logic [RFIDX_W-1:0] rdidx_r [OITF_DEPTH];

    logic               empty_s;
    logic               full_s;
    logic               long_op_s;
    logic               hazard_s;
    logic               stall_s;
    logic               go_s;
    logic               unit_rdy_s;
    logic               ready_s;
    logic               alloc_s;
    logic               retire_s;

    function automatic logic reg_match(input logic en,
                                       input logic [RFIDX_W-1:0] a,
                                       input logic [RFIDX_W-1:0] b);
        return en & (a == b);
    endfunction

    assign empty_s   = (wr_ptr_r == rd_ptr_r);
    assign full_s    = (wr_ptr_r[ITAG_W-1:0] == rd_ptr_r[ITAG_W-1:0]) &
                       (wr_ptr_r[ITAG_W] != rd_ptr_r[ITAG_W]);
    assign long_op_s = (i_grp_muldiv | i_grp_agu) & i_rdwen;

    // Dependency check against every pending long-latency destination.
    always_comb begin
        hazard_s = 1'b0;
        for (int i = 0; i < OITF_DEPTH; i++) begin
            if (vld_r[i] && (reg_match(i_rs1en, i_rs1idx, rdidx_r[i]) ||
                             reg_match(i_rs2en, i_rs2idx, rdidx_r[i]) ||
                             reg_match(i_rdwen, i_rdidx,  rdidx_r[i]))) begin
                hazard_s = 1'b1;
            end else begin
                hazard_s = hazard_s;
            end
        end
    end

    // A full table blocks allocation even if a retire lands this cycle.
    assign stall_s    = hazard_s | (long_op_s & full_s);
    assign go_s       = i_valid & ~i_flush & ~stall_s & ~i_illegal;
    assign unit_rdy_s = (i_grp_alu    & i_alu_ready)    |
                        (i_grp_bjp    & i_bjp_ready)    |
                        (i_grp_muldiv & i_muldiv_ready) |
                        (i_grp_agu    & i_agu_ready);

    // Handshake back to the decoder; illegal ops wait for the OITF to drain.
    always_comb begin
        if (i_illegal) begin
            ready_s = i_valid & ~i_flush & empty_s;
        end else begin
            ready_s = go_s & unit_rdy_s;
        end
    end

    assign i_ready         = ready_s;
    assign o_alu_valid     = go_s & i_grp_alu;
    assign o_bjp_valid     = go_s & i_grp_bjp;
    assign o_muldiv_valid  = go_s & i_grp_muldiv;
    assign o_agu_valid     = go_s & i_grp_agu;
    assign o_illegal_valid = i_valid & ready_s & i_illegal;
    assign o_itag          = wr_ptr_r[ITAG_W-1:0];

    assign alloc_s  = i_valid & ready_s & ~i_illegal & long_op_s;
    assign retire_s = i_lwb_valid & ~empty_s &
                      (i_lwb_itag == rd_ptr_r[ITAG_W-1:0]);

    // OITF entry storage: set on allocation, cleared on in-order retire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_r <= '0;
            for (int i = 0; i < OITF_DEPTH; i++) begin
                rdidx_r[i] <= '0;
            end
        end else begin
            if (retire_s) begin
                vld_r[rd_ptr_r[ITAG_W-1:0]] <= 1'b0;
            end else begin
                vld_r <= vld_r;
            end
            if (alloc_s) begin
                vld_r[wr_ptr_r[ITAG_W-1:0]]   <= 1'b1;
                rdidx_r[wr_ptr_r[ITAG_W-1:0]] <= i_rdidx;
            end else begin
                rdidx_r <= rdidx_r;
            end
        end
    end

    // Pointer, occupancy and sticky retire-error bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r  <= '0;
            rd_ptr_r  <= '0;
            cnt_r     <= '0;
            ret_err_r <= 1'b0;
        end else begin
            if (alloc_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (retire_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({alloc_s, retire_s})
                2'b10:   cnt_r <= cnt_r + PTR_ONE;
                2'b01:   cnt_r <= cnt_r - PTR_ONE;
                default: cnt_r <= cnt_r;
            endcase
            if (i_lwb_valid && !retire_s) begin
                ret_err_r <= 1'b1;
            end else begin
                ret_err_r <= ret_err_r;
            end
        end
    end

    assign o_oitf_empty = empty_s;
    assign o_oitf_full  = full_s;
    assign o_oitf_cnt   = cnt_r;
    assign o_ret_err    = ret_err_r;

endmodule
